// File: rtl/z_writeback_stage_pkg.sv
// Shared CPU definitions for the Z writeback stage: FSM encoding and data width.
`default_nettype none

package z_writeback_stage_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WB_LO = 2'b01,
    ST_WB_HI = 2'b10
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/z_writeback_stage_reg_nbit.sv
// reg_nbit: enable-load register with asynchronous active-low clear.
`default_nettype none

module reg_nbit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = en ? d : q_q;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/z_writeback_stage.sv
// z_writeback_stage: captures the 64-bit ALU result into Z, registers branch flags,
// drives Z onto the bus, and sequences MUL/DIV results into LO then HI.
`default_nettype none

module z_writeback_stage
  import z_writeback_stage_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                Zin,
  input  logic [2*DATA_W-1:0] C,
  input  logic                is_muldiv,
  input  logic                ZLowout,
  input  logic                ZHighout,
  output logic [DATA_W-1:0]   zbus_out,
  output logic [DATA_W-1:0]   LO,
  output logic [DATA_W-1:0]   HI,
  output logic                lo_we,
  output logic                hi_we,
  output logic                busy,
  output logic                z_valid,
  output logic                cond_zero,
  output logic                cond_neg,
  output logic                zin_drop
);

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] z_lo, z_hi;
  logic              capture;
  logic              z_valid_q, z_valid_d;
  logic              cond_zero_q, cond_zero_d;
  logic              cond_neg_q, cond_neg_d;
  logic              zin_drop_q, zin_drop_d;

  // Capture only from IDLE; a strobe during writeback is dropped, never queued.
  assign capture = (state_q == ST_IDLE) && Zin;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Zin && is_muldiv) state_d = ST_WB_LO;
      ST_WB_LO: state_d = ST_WB_HI;
      ST_WB_HI: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    lo_we = (state_q == ST_WB_LO);
    hi_we = (state_q == ST_WB_HI);
  end

  always_comb begin
    z_valid_d   = z_valid_q;
    cond_zero_d = cond_zero_q;
    cond_neg_d  = cond_neg_q;
    zin_drop_d  = zin_drop_q;
    if (capture) begin
      z_valid_d   = 1'b1;
      cond_zero_d = (C[DATA_W-1:0] == '0);
      cond_neg_d  = C[DATA_W-1];
    end
    if (Zin && busy) begin
      zin_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      z_valid_q   <= 1'b0;
      cond_zero_q <= 1'b0;
      cond_neg_q  <= 1'b0;
      zin_drop_q  <= 1'b0;
    end else begin
      z_valid_q   <= z_valid_d;
      cond_zero_q <= cond_zero_d;
      cond_neg_q  <= cond_neg_d;
      zin_drop_q  <= zin_drop_d;
    end
  end

  assign z_valid   = z_valid_q;
  assign cond_zero = cond_zero_q;
  assign cond_neg  = cond_neg_q;
  assign zin_drop  = zin_drop_q;

  reg_nbit #(.WIDTH(DATA_W)) u_z_low (
    .clock(clock), .clear(clear), .en(capture), .d(C[DATA_W-1:0]), .q(z_lo)
  );

  reg_nbit #(.WIDTH(DATA_W)) u_z_high (
    .clock(clock), .clear(clear), .en(capture), .d(C[2*DATA_W-1:DATA_W]), .q(z_hi)
  );

  reg_nbit #(.WIDTH(DATA_W)) u_lo (
    .clock(clock), .clear(clear), .en(lo_we), .d(z_lo), .q(LO)
  );

  reg_nbit #(.WIDTH(DATA_W)) u_hi (
    .clock(clock), .clear(clear), .en(hi_we), .d(z_hi), .q(HI)
  );

  // ZLowout wins if the control unit ever asserts both selects.
  always_comb begin
    zbus_out = '0;
    if (ZLowout) begin
      zbus_out = z_lo;
    end else if (ZHighout) begin
      zbus_out = z_hi;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_z_writeback_stage.sv
// Self-checking bench for z_writeback_stage: directed scenarios plus a randomized run
// against a cycle-count reference model.
`default_nettype none

module tb_z_writeback_stage;

  localparam int W = 32;

  logic           clock = 1'b0;
  logic           clear = 1'b0;
  logic           Zin = 1'b0;
  logic [2*W-1:0] C = '0;
  logic           is_muldiv = 1'b0;
  logic           ZLowout = 1'b0;
  logic           ZHighout = 1'b0;
  logic [W-1:0]   zbus_out, LO, HI;
  logic           lo_we, hi_we, busy, z_valid, cond_zero, cond_neg, zin_drop;

  int checks = 0;
  int errors = 0;

  // Reference model: m_rem counts writeback cycles still to come (2 = LO next, 1 = HI next).
  logic [2*W-1:0] m_z;
  logic [W-1:0]   m_lo, m_hi;
  logic           m_valid, m_cz, m_cn, m_drop;
  int             m_rem;

  z_writeback_stage #(.DATA_W(W)) dut (
    .clock(clock), .clear(clear), .Zin(Zin), .C(C), .is_muldiv(is_muldiv),
    .ZLowout(ZLowout), .ZHighout(ZHighout), .zbus_out(zbus_out), .LO(LO), .HI(HI),
    .lo_we(lo_we), .hi_we(hi_we), .busy(busy), .z_valid(z_valid),
    .cond_zero(cond_zero), .cond_neg(cond_neg), .zin_drop(zin_drop)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_z = '0; m_lo = '0; m_hi = '0;
    m_valid = 1'b0; m_cz = 1'b0; m_cn = 1'b0; m_drop = 1'b0; m_rem = 0;
  endtask

  function automatic logic [W-1:0] model_bus(input logic lo_sel, input logic hi_sel);
    if (lo_sel) return m_z[W-1:0];
    if (hi_sel) return m_z[2*W-1:W];
    return '0;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle 1ns past it.
  task automatic step(input logic zin, input logic [2*W-1:0] c, input logic md);
    Zin = zin; C = c; is_muldiv = md;
    @(posedge clock);
    if (m_rem == 0) begin
      if (zin) begin
        m_z = c; m_valid = 1'b1; m_cz = (c[W-1:0] == '0); m_cn = c[W-1];
        m_rem = md ? 2 : 0;
      end
    end else begin
      if (zin) m_drop = 1'b1;
      if (m_rem == 2) m_lo = m_z[W-1:0];
      else            m_hi = m_z[2*W-1:W];
      m_rem = m_rem - 1;
    end
    #1;
    Zin = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, z_valid, cond_zero, cond_neg, zin_drop, lo_we, hi_we} !== 7'b0 ||
        LO !== '0 || HI !== '0 || zbus_out !== '0) begin
      errors++;
      $display("FAIL reset_state got b=%b v=%b z=%b n=%b d=%b lw=%b hw=%b LO=%h HI=%h bus=%h want all 0",
               busy, z_valid, cond_zero, cond_neg, zin_drop, lo_we, hi_we, LO, HI, zbus_out);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    checks++;
    if (lo_we !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got lo_we=%b busy=%b want 1 1", lo_we, busy);
    end
    #2; clear = 1'b0; #1;
    model_reset();
    checks++;
    if ({busy, z_valid, cond_zero, cond_neg, zin_drop, lo_we, hi_we} !== 7'b0 ||
        LO !== '0 || HI !== '0) begin
      errors++;
      $display("FAIL rst_mid_async got b=%b v=%b lw=%b hw=%b LO=%h HI=%h want 0",
               busy, z_valid, lo_we, hi_we, LO, HI);
    end
    @(negedge clock); clear = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if (LO !== '0 || HI !== '0 || busy !== 1'b0 || hi_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after got LO=%h HI=%h busy=%b hw=%b want 0 0 0 0", LO, HI, busy, hi_we);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] lo0, hi0;
    lo0 = LO; hi0 = HI;
    step(1'b1, 64'h0000_0000_0000_0005, 1'b0);
    checks++;
    if (z_valid !== 1'b1 || cond_zero !== 1'b0 || cond_neg !== 1'b0 || busy !== 1'b0 ||
        lo_we !== 1'b0 || hi_we !== 1'b0) begin
      errors++;
      $display("FAIL add_flags got v=%b z=%b n=%b b=%b lw=%b hw=%b want 1 0 0 0 0 0",
               z_valid, cond_zero, cond_neg, busy, lo_we, hi_we);
    end
    ZLowout = 1'b1; #1;
    checks++;
    if (zbus_out !== 32'h5) begin errors++; $display("FAIL add_zlow got %h want 00000005", zbus_out); end
    ZLowout = 1'b0; ZHighout = 1'b1; #1;
    checks++;
    if (zbus_out !== 32'h0) begin errors++; $display("FAIL add_zhigh got %h want 00000000", zbus_out); end
    ZHighout = 1'b0;
    step(1'b0, '0, 1'b0);
    checks++;
    if (LO !== lo0 || HI !== hi0 || lo_we !== 1'b0 || hi_we !== 1'b0) begin
      errors++; $display("FAIL add_nowb got LO=%h HI=%h want %h %h", LO, HI, lo0, hi0);
    end
  endtask

  task automatic test_mul();
    step(1'b1, 64'h0000_0001_FFFF_FFFE, 1'b1);
    checks++;
    if (cond_neg !== 1'b1 || cond_zero !== 1'b0 || busy !== 1'b1 || lo_we !== 1'b1 || hi_we !== 1'b0) begin
      errors++; $display("FAIL mul_c1 got n=%b z=%b b=%b lw=%b hw=%b want 1 0 1 1 0",
                         cond_neg, cond_zero, busy, lo_we, hi_we);
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if (LO !== 32'hFFFF_FFFE || busy !== 1'b1 || hi_we !== 1'b1 || lo_we !== 1'b0) begin
      errors++; $display("FAIL mul_c2 got LO=%h b=%b hw=%b lw=%b want fffffffe 1 1 0", LO, busy, hi_we, lo_we);
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if (HI !== 32'h0000_0001 || busy !== 1'b0 || hi_we !== 1'b0) begin
      errors++; $display("FAIL mul_c3 got HI=%h b=%b hw=%b want 00000001 0 0", HI, busy, hi_we);
    end
  endtask

  task automatic test_drop();
    step(1'b1, 64'h0000_0003_0000_0007, 1'b1);
    step(1'b1, 64'h0, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if (LO !== 32'h7 || HI !== 32'h3 || cond_zero !== 1'b0 || zin_drop !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_result got LO=%h HI=%h z=%b drop=%b b=%b want 7 3 0 1 0",
                         LO, HI, cond_zero, zin_drop, busy);
    end
    ZLowout = 1'b1; #1;
    checks++;
    if (zbus_out !== 32'h7) begin errors++; $display("FAIL drop_zlow got %h want 00000007", zbus_out); end
    ZLowout = 1'b0; ZHighout = 1'b1; #1;
    checks++;
    if (zbus_out !== 32'h3) begin errors++; $display("FAIL drop_zhigh got %h want 00000003", zbus_out); end
    ZHighout = 1'b0;
    step(1'b1, 64'h5, 1'b0);
    checks++;
    if (zin_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b want 1", zin_drop); end
  endtask

  task automatic test_back_to_back();
    clear = 1'b0; #1; model_reset(); @(negedge clock); clear = 1'b1;
    step(1'b1, 64'h0000_000A_0000_000B, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 64'h0000_0022_8000_0011, 1'b1);
    checks++;
    if (busy !== 1'b1 || lo_we !== 1'b1 || cond_neg !== 1'b1 || HI !== 32'hA || LO !== 32'hB) begin
      errors++; $display("FAIL b2b_accept got b=%b lw=%b n=%b LO=%h HI=%h want 1 1 1 b a",
                         busy, lo_we, cond_neg, LO, HI);
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if (LO !== 32'h8000_0011 || HI !== 32'h22 || zin_drop !== 1'b0) begin
      errors++; $display("FAIL b2b_result got LO=%h HI=%h drop=%b want 80000011 00000022 0", LO, HI, zin_drop);
    end
  endtask

  task automatic test_bus_select();
    step(1'b1, 64'hCAFE_0000_BEEF_0001, 1'b0);
    ZLowout = 1'b1; ZHighout = 1'b1; #1;
    checks++;
    if (zbus_out !== 32'hBEEF_0001) begin errors++; $display("FAIL bus_both got %h want beef0001", zbus_out); end
    ZLowout = 1'b0; ZHighout = 1'b0; #1;
    checks++;
    if (zbus_out !== 32'h0) begin errors++; $display("FAIL bus_none got %h want 00000000", zbus_out); end
    step(1'b1, 64'h0, 1'b0);
    checks++;
    if (cond_zero !== 1'b1 || cond_neg !== 1'b0) begin
      errors++; $display("FAIL zero_flag got z=%b n=%b want 1 0", cond_zero, cond_neg);
    end
  endtask

  task automatic test_random();
    logic [2*W-1:0] c;
    logic           zl, zh;
    for (int i = 0; i < 300; i++) begin
      c = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) c[W-1:0] = '0;
      step(($urandom_range(0, 2) != 0), c, $urandom_range(0, 1) == 1);
      zl = ($urandom_range(0, 2) == 0); zh = $urandom_range(0, 1) == 1;
      ZLowout = zl; ZHighout = zh; #1;
      checks++;
      if (busy !== (m_rem != 0) || lo_we !== (m_rem == 2) || hi_we !== (m_rem == 1) ||
          LO !== m_lo || HI !== m_hi || z_valid !== m_valid || cond_zero !== m_cz ||
          cond_neg !== m_cn || zin_drop !== m_drop || zbus_out !== model_bus(zl, zh)) begin
        errors++;
        $display("FAIL rand_%0d got b=%b lw=%b hw=%b LO=%h HI=%h v=%b z=%b n=%b d=%b bus=%h want rem=%0d LO=%h HI=%h v=%b z=%b n=%b d=%b bus=%h",
                 i, busy, lo_we, hi_we, LO, HI, z_valid, cond_zero, cond_neg, zin_drop, zbus_out,
                 m_rem, m_lo, m_hi, m_valid, m_cz, m_cn, m_drop, model_bus(zl, zh));
      end
      ZLowout = 1'b0; ZHighout = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock); clear = 1'b1;
    test_reset_mid();
    test_add();
    test_mul();
    test_drop();
    test_back_to_back();
    test_bus_select();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
